// File: rtl/eth_pkg.sv
// Shared constants, FSM state type and header byte selection for the Ethernet TX frame builder.
package eth_pkg;

  localparam int unsigned ETH_HDR_LEN     = 14;
  localparam int unsigned ETH_MIN_PAYLOAD = 46;
  localparam int unsigned ETH_MAX_PAYLOAD = 1500;

  typedef enum logic [2:0] {
    IDLE_ST,
    HDR_ST,
    DATA_ST,
    PAD_ST,
    DROP_ST,
    WAIT_ST
  } eth_state_e;

  // Byte idx (0 = first on the wire) of the 14-byte header {dst, src, ethertype}.
  function automatic logic [7:0] hdr_byte(input logic [47:0] dst, input logic [47:0] src,
                                          input logic [15:0] etype, input logic [3:0] idx);
    logic [111:0] hdr;
    hdr = {dst, src, etype};
    return 8'(hdr >> (7'd8 * (7'd13 - 7'(idx))));
  endfunction

endpackage

// File: rtl/eth_tx_frame_builder.sv
// Prepends the Ethernet header to a payload byte stream, zero-pads short payloads and
// truncates long ones. The output stage is a single registered AXIS slice.
module eth_tx_frame_builder
  import eth_pkg::*;
#(
  parameter logic [47:0] SRC_MAC     = 48'h02_00_00_00_00_01,
  parameter int unsigned MIN_PAYLOAD = ETH_MIN_PAYLOAD,
  parameter int unsigned MAX_PAYLOAD = ETH_MAX_PAYLOAD
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [47:0] DST_MAC,
  input  logic [15:0] ETHERTYPE,
  input  logic [7:0]  S_AXIS_TDATA,
  input  logic        S_AXIS_TVALID,
  input  logic        S_AXIS_TLAST,
  output logic        S_AXIS_TREADY,
  output logic [7:0]  M_AXIS_TDATA,
  output logic        M_AXIS_TVALID,
  output logic        M_AXIS_TLAST,
  input  logic        M_AXIS_TREADY,
  output logic        FRAME_DONE,
  output logic        PADDED,
  output logic        TRUNCATED
);

  localparam logic [10:0] MinCnt  = 11'(MIN_PAYLOAD);
  localparam logic [10:0] MaxCnt  = 11'(MAX_PAYLOAD);
  localparam logic [3:0]  HdrLast = 4'(ETH_HDR_LEN - 1);

  eth_state_e  state_q, state_d;
  logic [47:0] dst_q, dst_d;
  logic [15:0] etype_q, etype_d;
  logic [3:0]  hdr_idx_q, hdr_idx_d;
  logic [10:0] pay_cnt_q, pay_cnt_d;
  logic [10:0] pay_cnt_inc;
  logic        pad_flag_q, pad_flag_d;
  logic        trunc_flag_q, trunc_flag_d;
  logic [7:0]  tdata_q, tdata_d;
  logic        tvalid_q, tvalid_d;
  logic        tlast_q, tlast_d;
  logic        out_load;

  // Next-state, output-register load and input handshake.
  always_comb begin
    state_d       = state_q;
    dst_d         = dst_q;
    etype_d       = etype_q;
    hdr_idx_d     = hdr_idx_q;
    pay_cnt_d     = pay_cnt_q;
    pad_flag_d    = pad_flag_q;
    trunc_flag_d  = trunc_flag_q;
    tdata_d       = tdata_q;
    tvalid_d      = tvalid_q;
    tlast_d       = tlast_q;
    S_AXIS_TREADY = 1'b0;
    pay_cnt_inc   = pay_cnt_q + 11'd1;
    out_load      = !tvalid_q || M_AXIS_TREADY;

    // A free or draining register empties unless a state below refills it.
    if (out_load) begin
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
    end

    case (state_q)
      IDLE_ST: begin
        // The first beat only opens the frame; it is consumed later in DATA_ST.
        if (S_AXIS_TVALID) begin
          dst_d        = DST_MAC;
          etype_d      = ETHERTYPE;
          hdr_idx_d    = '0;
          pay_cnt_d    = '0;
          pad_flag_d   = 1'b0;
          trunc_flag_d = 1'b0;
          state_d      = HDR_ST;
        end
      end
      HDR_ST: begin
        if (out_load) begin
          tdata_d   = hdr_byte(dst_q, SRC_MAC, etype_q, hdr_idx_q);
          tvalid_d  = 1'b1;
          hdr_idx_d = hdr_idx_q + 4'd1;
          if (hdr_idx_q == HdrLast) state_d = DATA_ST;
        end
      end
      DATA_ST: begin
        S_AXIS_TREADY = out_load;
        if (out_load && S_AXIS_TVALID) begin
          tdata_d   = S_AXIS_TDATA;
          tvalid_d  = 1'b1;
          pay_cnt_d = pay_cnt_inc;
          if (S_AXIS_TLAST) begin
            if (pay_cnt_inc >= MinCnt) begin
              tlast_d = 1'b1;
              state_d = WAIT_ST;
            end else begin
              state_d = PAD_ST;
            end
          end else if (pay_cnt_inc == MaxCnt) begin
            tlast_d      = 1'b1;
            trunc_flag_d = 1'b1;
            state_d      = DROP_ST;
          end
        end
      end
      PAD_ST: begin
        if (out_load) begin
          tdata_d   = 8'h00;
          tvalid_d  = 1'b1;
          pay_cnt_d = pay_cnt_inc;
          if (pay_cnt_inc == MinCnt) begin
            tlast_d    = 1'b1;
            pad_flag_d = 1'b1;
            state_d    = WAIT_ST;
          end
        end
      end
      DROP_ST: begin
        // Input drains regardless of whether the truncated TLAST byte is still stalled.
        S_AXIS_TREADY = 1'b1;
        if (S_AXIS_TVALID && S_AXIS_TLAST) state_d = WAIT_ST;
      end
      WAIT_ST: begin
        // Register is either empty (TLAST already taken during DROP_ST) or holds TLAST.
        if (out_load) state_d = IDLE_ST;
      end
      default: state_d = IDLE_ST;
    endcase
  end

  // State and output register with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= IDLE_ST;
      dst_q        <= '0;
      etype_q      <= '0;
      hdr_idx_q    <= '0;
      pay_cnt_q    <= '0;
      pad_flag_q   <= 1'b0;
      trunc_flag_q <= 1'b0;
      tdata_q      <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      dst_q        <= dst_d;
      etype_q      <= etype_d;
      hdr_idx_q    <= hdr_idx_d;
      pay_cnt_q    <= pay_cnt_d;
      pad_flag_q   <= pad_flag_d;
      trunc_flag_q <= trunc_flag_d;
      tdata_q      <= tdata_d;
      tvalid_q     <= tvalid_d;
      tlast_q      <= tlast_d;
    end
  end

  // Status pulses coincide with the downstream handshake of the TLAST byte.
  always_comb begin
    M_AXIS_TDATA  = tdata_q;
    M_AXIS_TVALID = tvalid_q;
    M_AXIS_TLAST  = tlast_q;
    FRAME_DONE    = tvalid_q && tlast_q && M_AXIS_TREADY;
    PADDED        = FRAME_DONE && pad_flag_q;
    TRUNCATED     = FRAME_DONE && trunc_flag_q;
  end

endmodule

// File: tb/tb_eth_tx_frame_builder.sv
// Self-checking bench for eth_tx_frame_builder: directed boundary frames plus randomized
// traffic with random stalls on both sides, checked against a byte-level frame model.
module tb_eth_tx_frame_builder;

  localparam logic [47:0] SRC    = 48'h02_00_00_00_00_01;
  localparam int          MINP   = 46;
  localparam int          MAXP   = 1500;
  localparam int          HDRLEN = 14;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [47:0] DST_MAC = '0;
  logic [15:0] ETHERTYPE = '0;
  logic [7:0]  S_AXIS_TDATA = '0;
  logic        S_AXIS_TVALID = 1'b0;
  logic        S_AXIS_TLAST = 1'b0;
  logic        S_AXIS_TREADY;
  logic [7:0]  M_AXIS_TDATA;
  logic        M_AXIS_TVALID;
  logic        M_AXIS_TLAST;
  logic        M_AXIS_TREADY = 1'b0;
  logic        FRAME_DONE;
  logic        PADDED;
  logic        TRUNCATED;

  always #5 CLK = ~CLK;

  eth_tx_frame_builder #(
    .SRC_MAC    (SRC),
    .MIN_PAYLOAD(MINP),
    .MAX_PAYLOAD(MAXP)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .DST_MAC      (DST_MAC),
    .ETHERTYPE    (ETHERTYPE),
    .S_AXIS_TDATA (S_AXIS_TDATA),
    .S_AXIS_TVALID(S_AXIS_TVALID),
    .S_AXIS_TLAST (S_AXIS_TLAST),
    .S_AXIS_TREADY(S_AXIS_TREADY),
    .M_AXIS_TDATA (M_AXIS_TDATA),
    .M_AXIS_TVALID(M_AXIS_TVALID),
    .M_AXIS_TLAST (M_AXIS_TLAST),
    .M_AXIS_TREADY(M_AXIS_TREADY),
    .FRAME_DONE   (FRAME_DONE),
    .PADDED       (PADDED),
    .TRUNCATED    (TRUNCATED)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] pay [1600];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  int done_cnt;
  bit pad_seen, trunc_seen, stray_flag, got_last, drv_ok;
  int drv_beats, first_valid_cyc, last_cyc;

  // Reference frame: header, payload cut to MAXP, zero fill up to MINP payload bytes.
  task automatic build_expected(input int len, input logic [47:0] dst, input logic [15:0] et);
    logic [47:0] s;
    int n;
    s = SRC;
    exp_q.delete();
    for (int i = 0; i < 6; i++) exp_q.push_back(dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) exp_q.push_back(s[47-8*i -: 8]);
    exp_q.push_back(et[15:8]);
    exp_q.push_back(et[7:0]);
    n = (len > MAXP) ? MAXP : len;
    for (int i = 0; i < n; i++) exp_q.push_back(pay[i]);
    while (exp_q.size() < HDRLEN + MINP) exp_q.push_back(8'h00);
  endtask

  function automatic int first_diff();
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      if (got_q[i] !== exp_q[i]) return i;
    if (got_q.size() != exp_q.size())
      return (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    return -1;
  endfunction

  function automatic int diff_got(input int idx);
    return (idx >= 0 && idx < got_q.size()) ? int'(got_q[idx]) : -1;
  endfunction

  function automatic int diff_exp(input int idx);
    return (idx >= 0 && idx < exp_q.size()) ? int'(exp_q[idx]) : -1;
  endfunction

  // Payload source; called aligned to posedge+1. DST/ETHERTYPE scrambled after beat 0.
  task automatic drive_frame(input int len, input int vprob, input logic [47:0] dst,
                             input logic [15:0] et, input int budget);
    int i = 0;
    int cyc = 0;
    bit acc;
    DST_MAC   = dst;
    ETHERTYPE = et;
    drv_ok    = 1'b1;
    while (i < len) begin
      if (!S_AXIS_TVALID && $urandom_range(99) < vprob) begin
        S_AXIS_TVALID = 1'b1;
        S_AXIS_TDATA  = pay[i];
        S_AXIS_TLAST  = (i == len - 1);
      end
      @(negedge CLK);
      acc = S_AXIS_TVALID && S_AXIS_TREADY;
      @(posedge CLK);
      #1;
      if (acc) begin
        i++;
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TLAST  = 1'b0;
        if (i == 1) begin
          DST_MAC   = 48'({$urandom(), $urandom()});
          ETHERTYPE = 16'($urandom());
        end
      end
      cyc++;
      if (cyc > budget) begin
        drv_ok = 1'b0;
        break;
      end
    end
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TLAST  = 1'b0;
    drv_beats     = i;
  endtask

  // Frame sink with random backpressure; stops after the TLAST handshake.
  task automatic collect_frame(input int rprob, input int budget);
    int cyc = 0;
    got_q.delete();
    done_cnt        = 0;
    pad_seen        = 1'b0;
    trunc_seen      = 1'b0;
    stray_flag      = 1'b0;
    got_last        = 1'b0;
    first_valid_cyc = -1;
    last_cyc        = -1;
    while (!got_last && cyc < budget) begin
      M_AXIS_TREADY = ($urandom_range(99) < rprob);
      @(negedge CLK);
      if (M_AXIS_TVALID && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (FRAME_DONE) begin
        done_cnt++;
        if (PADDED) pad_seen = 1'b1;
        if (TRUNCATED) trunc_seen = 1'b1;
      end else if (PADDED || TRUNCATED) begin
        stray_flag = 1'b1;
      end
      if (M_AXIS_TVALID && M_AXIS_TREADY) begin
        got_q.push_back(M_AXIS_TDATA);
        if (M_AXIS_TLAST) begin
          got_last = 1'b1;
          last_cyc = cyc;
        end
      end
      @(posedge CLK);
      #1;
      cyc++;
    end
    M_AXIS_TREADY = 1'b0;
  endtask

  task automatic run_frame(input int len, input int vprob, input int rprob,
                           input logic [47:0] dst, input logic [15:0] et);
    int budget;
    budget = 8 * (len + HDRLEN + MINP) + 100;
    build_expected(len, dst, et);
    fork
      drive_frame(len, vprob, dst, et, budget);
      collect_frame(rprob, budget);
    join
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b0;
    @(negedge CLK);
    vectors++;
    if ({M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDATA, S_AXIS_TREADY, FRAME_DONE, PADDED,
         TRUNCATED} !== 14'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got tv=%b tl=%b td=%h sr=%b fd=%b pd=%b tr=%b want all 0",
               M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDATA, S_AXIS_TREADY, FRAME_DONE, PADDED,
               TRUNCATED);
    end
    repeat (4) @(negedge CLK);
    vectors++;
    if (M_AXIS_TVALID !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_quiet: got tvalid=%b want 0", M_AXIS_TVALID);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_basic_64();
    int d;
    for (int i = 0; i < 64; i++) pay[i] = 8'(i);
    run_frame(64, 100, 100, 48'hFF_FF_FF_FF_FF_FF, 16'h0800);
    d = first_diff();
    vectors++;
    if (d != -1 || got_q.size() != 78) begin
      miscompares++;
      $display("FAIL basic64_bytes: size %0d want 78, at %0d got %0d want %0d",
               got_q.size(), d, diff_got(d), diff_exp(d));
    end
    vectors++;
    if (first_valid_cyc != 2) begin
      miscompares++;
      $display("FAIL basic64_latency: got %0d cycles want 2", first_valid_cyc);
    end
    vectors++;
    if (last_cyc != 2 + 77) begin
      miscompares++;
      $display("FAIL basic64_throughput: TLAST at cycle %0d want %0d", last_cyc, 79);
    end
    vectors++;
    if (!got_last || done_cnt != 1 || pad_seen || trunc_seen || stray_flag) begin
      miscompares++;
      $display("FAIL basic64_status: last=%0d done=%0d pad=%0d trunc=%0d stray=%0d want 1 1 0 0 0",
               got_last, done_cnt, pad_seen, trunc_seen, stray_flag);
    end
  endtask

  task automatic test_one_byte();
    int d;
    pay[0] = 8'hAB;
    run_frame(1, 100, 100, 48'h00_11_22_33_44_55, 16'h88B5);
    d = first_diff();
    vectors++;
    if (d != -1 || got_q.size() != 60) begin
      miscompares++;
      $display("FAIL onebyte_bytes: size %0d want 60, at %0d got %0d want %0d",
               got_q.size(), d, diff_got(d), diff_exp(d));
    end
    vectors++;
    if (!got_last || done_cnt != 1 || !pad_seen || trunc_seen || stray_flag) begin
      miscompares++;
      $display("FAIL onebyte_status: last=%0d done=%0d pad=%0d trunc=%0d stray=%0d want 1 1 1 0 0",
               got_last, done_cnt, pad_seen, trunc_seen, stray_flag);
    end
  endtask

  task automatic test_exact_min();
    int d;
    for (int i = 0; i < MINP; i++) pay[i] = 8'($urandom());
    run_frame(MINP, 70, 70, 48'hA0_B1_C2_D3_E4_F5, 16'h86DD);
    d = first_diff();
    vectors++;
    if (d != -1 || got_q.size() != 60) begin
      miscompares++;
      $display("FAIL min46_bytes: size %0d want 60, at %0d got %0d want %0d",
               got_q.size(), d, diff_got(d), diff_exp(d));
    end
    vectors++;
    if (!got_last || done_cnt != 1 || pad_seen || trunc_seen) begin
      miscompares++;
      $display("FAIL min46_status: last=%0d done=%0d pad=%0d trunc=%0d want 1 1 0 0",
               got_last, done_cnt, pad_seen, trunc_seen);
    end
  endtask

  task automatic test_exact_max();
    int d;
    for (int i = 0; i < MAXP; i++) pay[i] = 8'($urandom());
    run_frame(MAXP, 100, 100, 48'h12_34_56_78_9A_BC, 16'h0806);
    d = first_diff();
    vectors++;
    if (d != -1 || got_q.size() != 1514) begin
      miscompares++;
      $display("FAIL max1500_bytes: size %0d want 1514, at %0d got %0d want %0d",
               got_q.size(), d, diff_got(d), diff_exp(d));
    end
    vectors++;
    if (!got_last || done_cnt != 1 || pad_seen || trunc_seen) begin
      miscompares++;
      $display("FAIL max1500_status: last=%0d done=%0d pad=%0d trunc=%0d want 1 1 0 0",
               got_last, done_cnt, pad_seen, trunc_seen);
    end
  endtask

  task automatic test_truncate();
    int d;
    for (int i = 0; i < 1600; i++) pay[i] = 8'($urandom());
    // Slow sink so input draining overlaps a stalled TLAST byte.
    run_frame(1600, 100, 30, 48'hDE_AD_BE_EF_00_01, 16'h0800);
    d = first_diff();
    vectors++;
    if (d != -1 || got_q.size() != 1514) begin
      miscompares++;
      $display("FAIL trunc_bytes: size %0d want 1514, at %0d got %0d want %0d",
               got_q.size(), d, diff_got(d), diff_exp(d));
    end
    vectors++;
    if (!drv_ok || drv_beats != 1600) begin
      miscompares++;
      $display("FAIL trunc_drain: accepted %0d input beats want 1600", drv_beats);
    end
    vectors++;
    if (!got_last || done_cnt != 1 || pad_seen || !trunc_seen || stray_flag) begin
      miscompares++;
      $display("FAIL trunc_status: last=%0d done=%0d pad=%0d trunc=%0d stray=%0d want 1 1 0 1 0",
               got_last, done_cnt, pad_seen, trunc_seen, stray_flag);
    end
  endtask

  task automatic test_random_traffic();
    int len, d;
    logic [47:0] dst;
    logic [15:0] et;
    for (int k = 0; k < 200; k++) begin
      len = (k % 67 == 0) ? int'($urandom_range(1490, 1600)) : int'($urandom_range(1, 64));
      for (int i = 0; i < len; i++) pay[i] = 8'($urandom());
      dst = 48'({$urandom(), $urandom()});
      et  = 16'($urandom());
      run_frame(len, 50, 50, dst, et);
      d = first_diff();
      vectors++;
      if (d != -1) begin
        miscompares++;
        $display("FAIL rand_bytes frame %0d len %0d: size %0d want %0d, at %0d got %0d want %0d",
                 k, len, got_q.size(), exp_q.size(), d, diff_got(d), diff_exp(d));
      end
      vectors++;
      if (!got_last || !drv_ok || done_cnt != 1 || pad_seen != (len < MINP) ||
          trunc_seen != (len > MAXP) || stray_flag) begin
        miscompares++;
        $display("FAIL rand_status frame %0d len %0d: last=%0d drv=%0d done=%0d pad=%0d trunc=%0d",
                 k, len, got_last, drv_ok, done_cnt, pad_seen, trunc_seen);
      end
      if (!got_last || !drv_ok) break;
    end
  endtask

  task automatic test_reset_midframe();
    int idx = 0;
    int cyc = 0;
    int d;
    for (int i = 0; i < 64; i++) pay[i] = 8'(8'h80 + i);
    DST_MAC       = 48'h11_11_11_11_11_11;
    ETHERTYPE     = 16'h1234;
    M_AXIS_TREADY = 1'b1;
    S_AXIS_TVALID = 1'b1;
    S_AXIS_TLAST  = 1'b0;
    S_AXIS_TDATA  = pay[0];
    while (idx < 20 && cyc < 500) begin
      @(negedge CLK);
      if (S_AXIS_TVALID && S_AXIS_TREADY) idx++;
      @(posedge CLK);
      #1;
      S_AXIS_TDATA = pay[idx];
      cyc++;
    end
    vectors++;
    if (idx != 20) begin
      miscompares++;
      $display("FAIL midreset_reach: accepted %0d beats want 20", idx);
    end
    RESET         = 1'b1;
    S_AXIS_TVALID = 1'b0;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    @(negedge CLK);
    vectors++;
    if ({M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDATA, S_AXIS_TREADY, FRAME_DONE, PADDED,
         TRUNCATED} !== 14'd0) begin
      miscompares++;
      $display("FAIL midreset_outputs: got tv=%b tl=%b td=%h sr=%b fd=%b pd=%b tr=%b want all 0",
               M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDATA, S_AXIS_TREADY, FRAME_DONE, PADDED,
               TRUNCATED);
    end
    repeat (3) @(negedge CLK);
    vectors++;
    if (M_AXIS_TVALID !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_idle: got tvalid=%b want 0", M_AXIS_TVALID);
    end
    @(posedge CLK);
    #1;
    M_AXIS_TREADY = 1'b0;
    for (int i = 0; i < 30; i++) pay[i] = 8'($urandom());
    run_frame(30, 80, 80, 48'h02_33_44_55_66_77, 16'h9000);
    d = first_diff();
    vectors++;
    if (d != -1 || done_cnt != 1 || !pad_seen) begin
      miscompares++;
      $display("FAIL midreset_next: size %0d want 60, at %0d got %0d want %0d, done=%0d pad=%0d",
               got_q.size(), d, diff_got(d), diff_exp(d), done_cnt, pad_seen);
    end
  endtask

  initial begin
    test_reset();
    test_basic_64();
    test_one_byte();
    test_exact_min();
    test_exact_max();
    test_truncate();
    test_random_traffic();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/eth_tx_frame_builder.md
Name: eth_tx_frame_builder

Overview:
- Sits directly upstream of the RMII MAC TX AXIS input, in the TX AXIS clock domain.
- Takes a raw payload byte stream and prepends the 14-byte Ethernet header: destination MAC, source MAC, EtherType.
- Zero-pads short payloads to the 46-byte minimum and truncates payloads longer than MAX_PAYLOAD.
- The MAC downstream then adds preamble, SFD and FCS.

Parameters:
- SRC_MAC, 48'h02_00_00_00_00_01, source MAC address inserted in bytes 6..11.
- MIN_PAYLOAD, 46, minimum payload bytes; shorter payloads are zero-padded.
- MAX_PAYLOAD, 1500, maximum payload bytes; excess input bytes are consumed and discarded.

Ports:
- CLK  in  1  TX AXIS clock.
- RESET  in  1  synchronous, active-high reset.
- DST_MAC  in  48  destination MAC; sampled on the first payload beat of each frame.
- ETHERTYPE  in  16  EtherType; sampled on the first payload beat of each frame.
- S_AXIS_TDATA  in  8  payload byte.
- S_AXIS_TVALID  in  1  payload valid.
- S_AXIS_TLAST  in  1  last payload byte.
- S_AXIS_TREADY  out  1  payload accept.
- M_AXIS_TDATA  out  8  frame byte to the MAC.
- M_AXIS_TVALID  out  1  frame byte valid.
- M_AXIS_TLAST  out  1  last frame byte.
- M_AXIS_TREADY  in  1  MAC accept.
- FRAME_DONE  out  1  one-cycle pulse when the frame's last byte is accepted downstream.
- PADDED  out  1  one-cycle pulse, coincident with FRAME_DONE, when padding was inserted.
- TRUNCATED  out  1  one-cycle pulse, coincident with FRAME_DONE, when the payload was cut.

Behaviour:
- Reset: all outputs 0 (M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDATA, S_AXIS_TREADY, FRAME_DONE, PADDED, TRUNCATED). State returns to IDLE_ST. Any frame in flight is abandoned with no TLAST emitted.
- Output register: M_AXIS_* are registered. The register loads when !M_AXIS_TVALID || M_AXIS_TREADY. Data and TVALID hold stable while stalled.
- States and transitions:
  - IDLE_ST: S_AXIS_TREADY=0. When S_AXIS_TVALID=1, latch DST_MAC/ETHERTYPE, clear byte counter, go to HDR_ST. The first payload beat is not consumed here.
  - HDR_ST: emit 14 bytes in order: DST_MAC[47:40]..[7:0], then SRC_MAC MSB first, then ETHERTYPE[15:8], ETHERTYPE[7:0]. After byte 14 is loaded, go to DATA_ST.
  - DATA_ST: S_AXIS_TREADY = output register can load. Each accepted input beat is forwarded and pay_cnt increments. On an accepted beat with S_AXIS_TLAST:
    - pay_cnt+1 >= MIN_PAYLOAD: forward with M_AXIS_TLAST=1, go to WAIT_ST.
    - otherwise: forward with TLAST=0, go to PAD_ST.
    - On the accepted beat where pay_cnt+1 == MAX_PAYLOAD without TLAST: forward with TLAST=1, set trunc flag, go to DROP_ST.
  - PAD_ST: S_AXIS_TREADY=0. Emit 0x00 bytes until pay_cnt == MIN_PAYLOAD. The final pad byte carries TLAST. Set pad flag, go to WAIT_ST.
  - DROP_ST: S_AXIS_TREADY=1. Discard input beats up to and including TLAST, then go to WAIT_ST. The MAC side is not affected.
  - WAIT_ST: when the TLAST beat is accepted downstream, pulse FRAME_DONE (plus PADDED/TRUNCATED per flags), clear flags, go to IDLE_ST.
- Latency: first header byte is valid 2 cycles after S_AXIS_TVALID rises in IDLE_ST. Steady-state throughput is 1 byte/cycle with no bubbles between header, data and pad.
- Widths: pay_cnt is 11 bits unsigned and never exceeds MAX_PAYLOAD. Header index is 4 bits.
- Boundaries:
  - Payload exactly MIN_PAYLOAD: no pad, PADDED=0.
  - Payload exactly MAX_PAYLOAD with TLAST on the last byte: normal end, TRUNCATED=0.
  - One-byte frame (TVALID and TLAST together in IDLE_ST): header, 1 data byte, 45 pad bytes.
  - M_AXIS_TREADY low for any length at any point: no byte lost or duplicated.
  - DROP_ST while the output is still stalled: input draining continues independently of the stall.
  - DST_MAC/ETHERTYPE changes mid-frame have no effect on the frame in flight.

Decomposition:
- eth_pkg holds:
  - constants ETH_HDR_LEN=14, ETH_MIN_PAYLOAD=46, ETH_MAX_PAYLOAD=1500;
  - typedef enum for states IDLE_ST, HDR_ST, DATA_ST, PAD_ST, DROP_ST, WAIT_ST.
- No sub-module. The output register stage is inline (about 200 lines of RTL total).

Test Plan:
- 64-byte payload 0x00..0x3F, DST=FF:FF:FF:FF:FF:FF, ETHERTYPE=0x0800, TREADY=1 -> 78 bytes out:
  - bytes 1-6 = 0xFF; bytes 7-12 = SRC_MAC; bytes 13-14 = 0x08,0x00; bytes 15-78 = 0x00..0x3F;
  - TLAST on byte 78; FRAME_DONE=1, PADDED=0.
- 1-byte payload 0xAB -> 60 bytes out: byte 15 = 0xAB, bytes 16-60 = 0x00, TLAST on byte 60; PADDED pulses.
- Exactly 46-byte payload -> 60 bytes out, last byte is payload byte 46 with TLAST; PADDED=0.
- 1600-byte payload -> 1514 bytes out, TLAST on byte 1514; remaining 100 input beats accepted and discarded; TRUNCATED pulses once.
- Random 50% M_AXIS_TREADY and S_AXIS_TVALID over 200 frames of length 1..1600 -> output matches reference-model bytes exactly; one FRAME_DONE per frame.
- RESET asserted at payload byte 20 of a frame -> next cycle all outputs 0, state IDLE_ST; next frame is built correctly from header byte 1.
